// File: rtl/game_timing_pkg.sv
// Shared timing constants for the game timebase.
//   DEF_CTR_W : default counter/divisor width
//   DEF_DIV   : divisor loaded at reset (100 reproduces the legacy game_clock rate)
//   ch_w()    : width of a channel-select field, never less than one bit
package game_timing_pkg;

    localparam int DEF_CTR_W  = 32;
    localparam int DEF_DIV    = 100;
    localparam int DEF_NUM_CH = 4;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CH_W = ch_w(DEF_NUM_CH);

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: free-running counter producing a one-clock tick and a
// 50% duty square wave, with a run-time loadable divisor and enable.
//   clock, reset : system clock, synchronous active-high reset
//   active       : global run qualifier (low while paused)
//   load         : load load_div/load_en, restart the count
//   tick, sq     : registered tick pulse and square wave
//   div          : current divisor register
module tick_channel
    import game_timing_pkg::*;
#(
    parameter int CTR_W       = DEF_CTR_W,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter bit EN_RESET    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             active,
    input  logic             load,
    input  logic [CTR_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick,
    output logic             sq,
    output logic [CTR_W-1:0] div
);

    localparam logic [CTR_W-1:0] RST_DIV = CTR_W'(DEFAULT_DIV);
    localparam logic [CTR_W-1:0] ONE     = CTR_W'(1);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CTR_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CTR_W-1:0] d_eff;

    always_comb begin
        // A zero divisor behaves as divide-by-one.
        d_eff  = (div_q == '0) ? ONE : div_q;
        ctr_d  = ctr_q;
        div_d  = div_q;
        en_d   = en_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (load) begin
            // A write restarts the count and suppresses any coincident wrap.
            div_d = load_div;
            en_d  = load_en;
            ctr_d = '0;
        end else if (active && en_q) begin
            // >= so a divisor lowered below the running count wraps at once.
            if (ctr_q >= d_eff - ONE) begin
                ctr_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                ctr_d = ctr_q + ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctr_q  <= '0;
            div_q  <= RST_DIV;
            en_q   <= EN_RESET;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            ctr_q  <= ctr_d;
            div_q  <= div_d;
            en_q   <= en_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign div  = div_q;

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel programmable timebase for the game logic. Every channel yields
// a one-clock tick enable and a square wave; consumers stay on `clock`.
//   clock, reset : system clock, synchronous active-high reset
//   pause        : freezes all channels (config writes still accepted)
//   cfg_wr/cfg_ch/cfg_div/cfg_en : single-cycle config write to one channel
//   tick, sq     : per-channel registered outputs
//   div_rd       : per-channel divisor readback, ch0 in the LSBs
module game_tick_gen
    import game_timing_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CTR_W       = DEF_CTR_W,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int EN_RESET    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pause,
    input  logic                    cfg_wr,
    input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CTR_W-1:0]        cfg_div,
    input  logic                    cfg_en,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [NUM_CH*CTR_W-1:0] div_rd
);

    localparam int CH_W = ch_w(NUM_CH);

    logic              active;
    logic [NUM_CH-1:0] load;

    assign active = ~pause;

    // Addresses at or beyond NUM_CH match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = cfg_wr && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CTR_W       (CTR_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .EN_RESET    (EN_RESET != 0)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .active   (active),
            .load     (load[i]),
            .load_div (cfg_div),
            .load_en  (cfg_en),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .div      (div_rd[i*CTR_W +: CTR_W])
        );
    end

endmodule

// File: tb/tb_game_tick_gen.sv
module tb_game_tick_gen;
    import game_timing_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         pause = 1'b0;
    logic         cfg_wr = 1'b0, cfg_en = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [31:0]  cfg_div = '0;
    logic [3:0]   tick, sq;
    logic [127:0] div_rd;

    // Second instance with NUM_CH=3 so an out-of-range cfg_ch (3) is expressible.
    logic         cfg_wr3 = 1'b0, cfg_en3 = 1'b0;
    logic [1:0]   cfg_ch3 = '0;
    logic [7:0]   cfg_div3 = '0;
    logic [2:0]   tick3, sq3;
    logic [23:0]  div_rd3;

    always #5 clock = ~clock;

    game_tick_gen #(.NUM_CH(4), .CTR_W(32), .DEFAULT_DIV(100), .EN_RESET(1)) u_dut (
        .clock(clock), .reset(reset), .pause(pause),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
        .tick(tick), .sq(sq), .div_rd(div_rd)
    );

    game_tick_gen #(.NUM_CH(3), .CTR_W(8), .DEFAULT_DIV(5), .EN_RESET(1)) u_dut3 (
        .clock(clock), .reset(reset), .pause(pause),
        .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_en(cfg_en3),
        .tick(tick3), .sq(sq3), .div_rd(div_rd3)
    );

    function automatic logic [31:0] dr(input int ch);
        return div_rd[ch*32 +: 32];
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: got %0h, no expectation queued", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) passes++;
            else $error("FAIL %s: got %0h expected %0h", x.tag, obs, x.exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic wr(input int ch, input logic [31:0] d, input logic e);
        cfg_ch  = 2'(ch);
        cfg_div = d;
        cfg_en  = e;
        cfg_wr  = 1'b1;
        @(negedge clock);
        cfg_wr  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic s;
        logic t;

        // ---- reset state
        repeat (2) step();
        push("rst_tick", 32'h0); pop_chk({28'h0, tick});
        push("rst_sq", 32'h0);   pop_chk({28'h0, sq});
        for (int i = 0; i < 4; i++) begin
            push("rst_div", 32'd100); pop_chk(dr(i));
        end
        push("rst_div3", 32'h050505); pop_chk({8'h0, div_rd3});

        // ---- 1: defaults, ticks at edges 100/200/300 after release
        reset = 1'b0;
        s = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            t = (k % 100 == 0);
            if (t) s = ~s;
            push("t1_tick", t ? 32'hF : 32'h0);
            push("t1_sq", s ? 32'hF : 32'h0);
        end
        for (int k = 1; k <= 300; k++) begin
            step();
            pop_chk({28'h0, tick});
            pop_chk({28'h0, sq});
        end

        // ---- 2: ch1 div=4
        do_reset();
        push("t2_div1", 32'd4);
        push("t2_tick_w", 32'd0);
        wr(1, 32'd4, 1'b1);
        pop_chk(dr(1));
        pop_chk({31'h0, tick[1]});
        s = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            t = (k % 4 == 0);
            if (t) s = ~s;
            push("t2_tick1", {31'h0, t});
            push("t2_sq1", {31'h0, s});
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            pop_chk({31'h0, tick[1]});
            pop_chk({31'h0, sq[1]});
        end

        // ---- 3: ch2 div=0 then div=1 -> tick every cycle
        do_reset();
        push("t3_tick_w0", 32'd0);
        wr(2, 32'd0, 1'b1);
        pop_chk({31'h0, tick[2]});
        for (int k = 1; k <= 4; k++) begin
            push("t3_tick_d0", 32'd1);
            push("t3_sq_d0", {31'h0, k[0]});
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            pop_chk({31'h0, tick[2]});
            pop_chk({31'h0, sq[2]});
        end
        push("t3_tick_w1", 32'd0);
        push("t3_sq_w1", 32'd0);
        wr(2, 32'd1, 1'b1);
        pop_chk({31'h0, tick[2]});
        pop_chk({31'h0, sq[2]});
        for (int k = 1; k <= 4; k++) begin
            push("t3_tick_d1", 32'd1);
            push("t3_sq_d1", {31'h0, k[0]});
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            pop_chk({31'h0, tick[2]});
            pop_chk({31'h0, sq[2]});
        end

        // ---- 4: ch0 div=10, pause 7 cycles with count held at 5.
        // From 5 the count needs edges to 6,7,8,9 and then the wrap edge.
        do_reset();
        wr(0, 32'd10, 1'b1);
        for (int k = 1; k <= 5; k++) push("t4_run", 32'd0);
        for (int k = 1; k <= 5; k++) begin step(); pop_chk({31'h0, tick[0]}); end
        pause = 1'b1;
        for (int k = 1; k <= 7; k++) push("t4_pause", 32'd0);
        for (int k = 1; k <= 7; k++) begin step(); pop_chk({28'h0, tick}); end
        pause = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("t4_tick0", {31'h0, k == 5});
            push("t4_sq0", {31'h0, k == 5});
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            pop_chk({31'h0, tick[0]});
            pop_chk({31'h0, sq[0]});
        end

        // ---- 5: ch3 div=8 at count 6, rewrite div=3; then write on a wrap edge
        do_reset();
        wr(3, 32'd8, 1'b1);
        for (int k = 1; k <= 6; k++) push("t5_run", 32'd0);
        for (int k = 1; k <= 6; k++) begin step(); pop_chk({31'h0, tick[3]}); end
        push("t5_tick_w", 32'd0);
        wr(3, 32'd3, 1'b1);
        pop_chk({31'h0, tick[3]});
        for (int k = 1; k <= 8; k++) begin
            push("t5_tick3", {31'h0, (k == 3) || (k == 6)});
            push("t5_sq3", {31'h0, (k >= 3) && (k < 6)});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            pop_chk({31'h0, tick[3]});
            pop_chk({31'h0, sq[3]});
        end
        push("t5_wrap_tick", 32'd0);
        push("t5_wrap_sq", 32'd0);
        wr(3, 32'd3, 1'b1);
        pop_chk({31'h0, tick[3]});
        pop_chk({31'h0, sq[3]});
        for (int k = 1; k <= 3; k++) begin
            push("t5_tick3b", {31'h0, k == 3});
            push("t5_sq3b", {31'h0, k == 3});
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            pop_chk({31'h0, tick[3]});
            pop_chk({31'h0, sq[3]});
        end

        // ---- 6c: en=0 write freezes sq, silences tick
        do_reset();
        wr(1, 32'd2, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            push("t6c_tick", {31'h0, k == 2});
            push("t6c_sq", {31'h0, k >= 2});
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            pop_chk({31'h0, tick[1]});
            pop_chk({31'h0, sq[1]});
        end
        push("t6c_off_tick", 32'd0);
        push("t6c_off_sq", 32'd1);
        wr(1, 32'd2, 1'b0);
        pop_chk({31'h0, tick[1]});
        pop_chk({31'h0, sq[1]});
        for (int k = 1; k <= 5; k++) begin
            push("t6c_frz_tick", 32'd0);
            push("t6c_frz_sq", 32'd1);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            pop_chk({31'h0, tick[1]});
            pop_chk({31'h0, sq[1]});
        end
        wr(1, 32'd2, 1'b1);
        for (int k = 1; k <= 2; k++) push("t6c_resume", {31'h0, k == 2});
        for (int k = 1; k <= 2; k++) begin step(); pop_chk({31'h0, tick[1]}); end

        // ---- 6a: reset with coincident cfg_wr and pause -> reset values
        do_reset();
        wr(0, 32'd2, 1'b1);
        push("t6a_pre_sq", 32'd1);
        repeat (2) step();
        pop_chk({31'h0, sq[0]});
        push("t6a_tick", 32'd0);
        push("t6a_sq", 32'd0);
        push("t6a_div", 32'd100);
        reset = 1'b1; pause = 1'b1;
        cfg_ch = 2'd0; cfg_div = 32'd7; cfg_en = 1'b0; cfg_wr = 1'b1;
        step();
        reset = 1'b0; pause = 1'b0; cfg_wr = 1'b0;
        pop_chk({28'h0, tick});
        pop_chk({28'h0, sq});
        pop_chk(dr(0));
        push("t6a_t99", 32'd0);
        push("t6a_t100", 32'd1);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k >= 99) pop_chk({31'h0, tick[0]});
        end

        // ---- 6b: out-of-range channel write on the 3-channel instance
        do_reset();
        for (int k = 1; k <= 6; k++) push("t6b_tick3", (k == 5) ? 32'h7 : 32'h0);
        push("t6b_div3", 32'h050505);
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                cfg_ch3 = 2'd3; cfg_div3 = 8'd2; cfg_en3 = 1'b0; cfg_wr3 = 1'b1;
            end
            step();
            cfg_wr3 = 1'b0;
            pop_chk({29'h0, tick3});
        end
        pop_chk({8'h0, div_rd3});

        checks++;
        assert (sb.size() == 0) passes++;
        else $error("FAIL sb_leftover: got %0d expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
